// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and FSM state encodings for the SPI slave port.
package spi_pkg;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection on the synchronized level.
// Ports: clk, rst_n (sync, active-low), din (async input), rise/fall (one-cycle edge pulses).
// Edges are suppressed until the pipeline has refilled after reset, so a pin that sits
// away from RST_VAL across reset never produces a spurious edge.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic [STAGES:0]   vld_q, vld_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(din);
        vld_d  = {vld_q[STAGES-1:0], 1'b1};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            vld_q  <= '0;
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
            prev_q <= prev_d;
        end
    end

    assign rise = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 slave (MSB first) sampled entirely in the clk domain.
// Ports: clk, rst_n (sync, active-low); SCLK/SS_N/MOSI_SLAVE in, MISO_SLAVE out;
// tx_data/tx_load feed the TX holding register; rx_data/rx_valid report each byte;
// busy while a frame is active. Optional frame_err output under SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK_SLAVE,
    input  logic                  SS_N_SLAVE,
    input  logic                  MOSI_SLAVE,
    output logic                  MISO_SLAVE,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic                  frame_err,
`endif
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic                  sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  last_bit;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                  frame_err_q, frame_err_d;
`endif

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK_SLAVE), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .din(SS_N_SLAVE), .rise(ss_rise), .fall(ss_fall)
    );

    assign rx_word  = {rx_sh_q, mosi_q[SYNC_STAGES-1]};
    assign last_bit = cnt_q == CW'(DATA_WIDTH - 1);

    always_comb begin
        mosi_d     = (mosi_q << 1) | SYNC_STAGES'(MOSI_SLAVE);
        hold_d     = tx_load ? tx_data : hold_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        miso_d     = miso_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                if (ss_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_sh_d = hold_d;
                miso_d  = hold_d[DATA_WIDTH-1];
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_sh_d = rx_word[DATA_WIDTH-2:0];
                    cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
                    if (last_bit) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // A falling edge with the counter at zero follows a completed byte:
                    // start the next byte from the holding register instead of shifting.
                    if (cnt_q == '0) begin
                        tx_sh_d = hold_d;
                        miso_d  = hold_d[DATA_WIDTH-1];
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        miso_d  = tx_sh_q[DATA_WIDTH-2];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ss_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_d = (state_q != ST_IDLE) && (cnt_q != '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            hold_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            mosi_q     <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            hold_q     <= hold_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            mosi_q     <= mosi_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign MISO_SLAVE = miso_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = state_q != ST_IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err  = frame_err_q;
`endif
endmodule

// File: doc/spi_slave_port.md
SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the bits per SPI byte and the width of tx_data/rx_data.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for SCLK_SLAVE, SS_N_SLAVE and MOSI_SLAVE.
REQ-003 clk  input  1  system clock; the sole clock.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 SCLK_SLAVE  input  1  SPI clock from master, asynchronous to clk.
REQ-006 SS_N_SLAVE  input  1  SPI slave select, active-low, asynchronous.
REQ-007 MOSI_SLAVE  input  1  serial data from master.
REQ-008 MISO_SLAVE  output  1  serial data to master.
REQ-009 tx_data  input  DATA_WIDTH  response byte offered by user logic.
REQ-010 tx_load  input  1  one-cycle strobe capturing tx_data into the TX holding register.
REQ-011 rx_data  output  DATA_WIDTH  last complete byte received.
REQ-012 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-013 busy  output  1  high while synchronized SS_N is low.

Function
REQ-014 The protocol SHALL be SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample MOSI on SCLK rising, change MISO on SCLK falling.
REQ-015 SCLK_SLAVE, SS_N_SLAVE and MOSI_SLAVE SHALL each pass through SYNC_STAGES flip-flops; edges SHALL be detected on synchronized values only; supported SCLK is at most clk/8.
REQ-016 The FSM SHALL have states IDLE (SS_N high), LOAD (one cycle after the SS_N falling edge) and SHIFT (SS_N low, bits counting).
REQ-017 IDLE->LOAD on the synchronized SS_N falling edge; LOAD->SHIFT unconditionally; any state->IDLE on the synchronized SS_N rising edge.
REQ-018 In LOAD, the TX shift register SHALL load the holding register, MISO_SLAVE SHALL present its MSB, and the bit counter SHALL clear.
REQ-019 In SHIFT, each SCLK rising edge SHALL shift the synchronized MOSI into the RX shift register LSB and increment the bit counter modulo DATA_WIDTH.
REQ-020 In SHIFT, each SCLK falling edge SHALL shift the TX register left and present the new MSB on MISO_SLAVE.
REQ-021 On the DATA_WIDTH-th rising edge, rx_data SHALL update and rx_valid SHALL pulse for exactly one clk cycle; pin-edge-to-rx_valid latency is SYNC_STAGES+1 clk cycles.
REQ-022 At that byte boundary, the TX register SHALL reload from the holding register so that multi-byte frames continue without gaps.
REQ-023 A tx_load in the same cycle as a reload SHALL bypass, so the new tx_data is sent.
REQ-024 If no tx_load has occurred since the last reload, the holding value SHALL be resent.
REQ-025 An SS_N rising edge mid-byte SHALL discard the partial byte: no rx_valid, counter cleared, rx_data unchanged.
REQ-026 MISO_SLAVE SHALL drive 0 in IDLE.
REQ-027 SCLK edges while SS_N is high SHALL be ignored.

Reset
REQ-028 While rst_n=0 at a clk edge, the block SHALL clear: state=IDLE, MISO_SLAVE=0, rx_data=0, rx_valid=0, busy=0, holding/shift registers=0, counter=0, synchronizers=idle levels (SCLK 0, SS_N 1, MOSI 0).
REQ-029 Reset released mid-frame (SS_N low) SHALL keep the block in IDLE until SS_N goes high and then low again.

Configuration
REQ-030 Macro SPI_SLAVE_FRAME_ERR_EN: when defined, the block SHALL add output frame_err (1 bit), pulsed for one cycle on an SS_N rising edge with a nonzero bit counter, and reset to 0.
REQ-031 When the macro is undefined, the frame_err port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package spi_pkg SHALL hold the DATA_WIDTH default, the SYNC_STAGES default and the FSM state encodings (IDLE, LOAD, SHIFT).
REQ-033 The block SHALL use sub-module spi_sync_edge (synchronizer plus rise/fall detector), instantiated for SCLK and SS_N.

Verification
REQ-034 The bench SHALL cover: tx_load 8'hA5; master sends 8'h3C at clk/8 -> master receives 8'hA5, rx_data=8'h3C with a single rx_valid pulse.
REQ-035 The bench SHALL cover: a 3-byte frame 8'h01,8'h02,8'h03 with tx_load 8'h10 only -> three rx_valid pulses in order; master receives 8'h10 three times.
REQ-036 The bench SHALL cover: tx_load 8'h77 in the same cycle as the 8th rising edge of byte 1 -> byte 2 on MISO is 8'h77.
REQ-037 The bench SHALL cover: SS_N raised after 5 bits -> no rx_valid, rx_data unchanged; next full byte 8'hC3 is received correctly; frame_err pulses once when the macro is defined.
REQ-038 The bench SHALL cover: rst_n low for 2 cycles mid-byte -> all outputs reset; the rest of the frame is ignored; next frame 8'h5A is received correctly.
REQ-039 The bench SHALL cover: SCLK toggling with SS_N high -> no rx_valid, MISO_SLAVE=0, busy=0.
